gmii_tx_framer: RTL

//  Ethernet MAC transmit framer in the rgmii_txclk domain, directly upstream of the GMII->RGMII DDR

---
 rtl/gmii_tx_framer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_framer.sv
// Ethernet MAC transmit framer: wraps a valid/ready payload stream in preamble, SFD,
// zero padding and CRC32 FCS, and enforces the inter-frame gap on the GMII side.
module gmii_tx_framer #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_LEN      = 12
) (
    input  logic       rgmii_txclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_txdv,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_PAD  = 3'd4;
    localparam logic [2:0] ST_FCS  = 3'd5;
    localparam logic [2:0] ST_IFG  = 3'd6;

    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = '1;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);

    logic [2:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] byte_cnt, byte_cnt_nxt;
    logic [31:0] crc, crc_nxt;
    logic [31:0] crc_inv;
    logic [7:0]  fcs_byte;
    logic [7:0]  txd_nxt;
    logic        txdv_nxt;
    logic        done_nxt;
    logic        urun_nxt;

    function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign tx_ready = (state == ST_DATA);
    assign crc_inv  = ~crc;

    always_comb begin
        case (cnt[1:0])
            2'd0:    fcs_byte = crc_inv[7:0];
            2'd1:    fcs_byte = crc_inv[15:8];
            2'd2:    fcs_byte = crc_inv[23:16];
            default: fcs_byte = crc_inv[31:24];
        endcase
    end

    // Outputs are registered, so each state computes the byte for the following cycle;
    // SFD is already on the wire during the first DATA cycle, keeping txdv gap-free.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        byte_cnt_nxt = byte_cnt;
        crc_nxt      = crc;
        txd_nxt      = '0;
        txdv_nxt     = 1'b0;
        done_nxt     = 1'b0;
        urun_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                crc_nxt      = CRC_INIT;
                byte_cnt_nxt = '0;
                cnt_nxt      = 16'd1;
                if (tx_valid) begin
                    txd_nxt   = PRE_BYTE;
                    txdv_nxt  = 1'b1;
                    state_nxt = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
                end
            end
            ST_PRE: begin
                txd_nxt  = PRE_BYTE;
                txdv_nxt = 1'b1;
                cnt_nxt  = cnt + 16'd1;
                if (cnt >= PRE_LAST) begin
                    state_nxt = ST_SFD;
                end
            end
            ST_SFD: begin
                txd_nxt   = SFD_BYTE;
                txdv_nxt  = 1'b1;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (tx_valid) begin
                    txd_nxt  = tx_data;
                    txdv_nxt = 1'b1;
                    crc_nxt  = crc_update(crc, tx_data);
                    if (byte_cnt != '1) begin
                        byte_cnt_nxt = byte_cnt + 16'd1;
                    end
                    if (tx_last) begin
                        cnt_nxt   = '0;
                        state_nxt = (byte_cnt_nxt < MIN_LEN) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // The abort cycle itself is the first idle cycle of the gap.
                    urun_nxt  = 1'b1;
                    cnt_nxt   = 16'd1;
                    state_nxt = ST_IFG;
                end
            end
            ST_PAD: begin
                txdv_nxt = 1'b1;
                crc_nxt  = crc_update(crc, 8'h00);
                if (byte_cnt != '1) begin
                    byte_cnt_nxt = byte_cnt + 16'd1;
                end
                if (byte_cnt_nxt >= MIN_LEN) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_FCS;
                end
            end
            ST_FCS: begin
                txd_nxt  = fcs_byte;
                txdv_nxt = 1'b1;
                cnt_nxt  = cnt + 16'd1;
                if (cnt[1:0] == 2'd3) begin
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IFG;
                end
            end
            ST_IFG: begin
                cnt_nxt = cnt + 16'd1;
                if (cnt >= IFG_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rgmii_txclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            byte_cnt   <= '0;
            crc        <= CRC_INIT;
            gmii_txd   <= '0;
            gmii_txdv  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            byte_cnt   <= byte_cnt_nxt;
            crc        <= crc_nxt;
            gmii_txd   <= txd_nxt;
            gmii_txdv  <= txdv_nxt;
            busy       <= (state_nxt != ST_IDLE);
            frame_done <= done_nxt;
            underrun   <= urun_nxt;
        end
    end

endmodule
